// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizing for the memory-port arbiter: FSM state
// encodings and the owner tag used to route read responses.
package mem_port_arbiter_pkg;

    localparam int DEF_MEM_LAT      = 4;
    localparam int DEF_STARVE_LIMIT = 4;
    localparam int DEF_AW           = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_I_OWN = 2'd1,
        ST_D_OWN = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arb_outstanding_ctr.sv
// Saturating up/down counter of reads in flight to memory; flags when the
// count will be zero after this cycle so DRAIN can exit on the last response.
module mem_arb_outstanding_ctr #(
    parameter int MAX_CNT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic cnt_zero_next
);

    localparam int CW = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_CNT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec && !inc && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_zero_next = (cnt_d == '0);

    // More reads than the pipeline depth, or a response nobody asked for.
    overflow_chk: assert property (@(posedge clk) disable iff (rst)
        !(inc && !dec && cnt_q == CNT_MAX));
    underflow_chk: assert property (@(posedge clk) disable iff (rst)
        !(dec && !inc && cnt_q == '0));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single pipelined memory port between I-cache fill and
// D-cache traffic, granting whole transactions and routing read data back.
// Handshake: a side raises req and holds it for its whole transaction; gnt
// rises the cycle after the arbiter accepts it in IDLE, per-cycle en strobes
// are forwarded only while gnt is high, and dropping req ends ownership.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT      = DEF_MEM_LAT,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int AW           = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic          i_en,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_valid,
    output logic [AW-1:0] i_data,
    input  logic          d_req,
    input  logic          d_en,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [AW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_valid,
    output logic [AW-1:0] d_data,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [AW-1:0] mem_din,
    input  logic [AW-1:0] mem_dout,
    input  logic          mem_valid,
    output logic          busy
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_e    state_q, state_d;
    owner_e        last_owner_q, last_owner_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          cnt_zero_next;
    logic          rd_issue;

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        starve_d     = starve_q;
        case (state_q)
            ST_IDLE: begin
                // D wins unless I has waited out the starvation limit.
                if (d_req && !(i_req && starve_q == STARVE_MAX)) begin
                    state_d      = ST_D_OWN;
                    last_owner_d = OWNER_D;
                    if (i_req && starve_q != STARVE_MAX) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (i_req) begin
                    state_d      = ST_I_OWN;
                    last_owner_d = OWNER_I;
                    starve_d     = '0;
                end
            end
            ST_D_OWN: if (!d_req) state_d = ST_DRAIN;
            ST_I_OWN: if (!i_req) state_d = ST_DRAIN;
            ST_DRAIN: if (cnt_zero_next) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_owner_q <= OWNER_D;
            starve_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            starve_q     <= starve_d;
        end
    end

    assign i_gnt = (state_q == ST_I_OWN);
    assign d_gnt = (state_q == ST_D_OWN);
    assign busy  = (state_q != ST_IDLE);

    always_comb begin
        mem_en   = 1'b0;
        mem_wr   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (i_gnt) begin
            mem_en   = i_en;
            mem_addr = i_addr;
        end else if (d_gnt) begin
            mem_en   = d_en;
            mem_wr   = d_en & d_wr;
            mem_addr = d_addr;
            mem_din  = d_wdata;
        end
    end

    assign rd_issue = mem_en & ~mem_wr;

    mem_arb_outstanding_ctr #(
        .MAX_CNT(MEM_LAT)
    ) u_outstanding (
        .clk          (clk),
        .rst          (rst),
        .inc          (rd_issue),
        .dec          (mem_valid),
        .cnt_zero_next(cnt_zero_next)
    );

    // Responses follow the side that issued them, even through DRAIN.
    assign i_valid = mem_valid & (last_owner_q == OWNER_I);
    assign d_valid = mem_valid & (last_owner_q == OWNER_D);
    assign i_data  = i_valid ? mem_dout : '0;
    assign d_data  = d_valid ? mem_dout : '0;

endmodule
